// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M constants, FSM state encoding and the two's-complement helper
// used by operand preparation and the result sign fix.
package muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [4:0] ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return -v;
  endfunction

endpackage

// File: rtl/muldiv_unit_magnitude_conv.sv
// Splits an operand into magnitude and sign flag; unsigned operands pass
// through untouched with the flag cleared.
module magnitude_conv
  import muldiv_unit_pkg::*;
(
  input  logic [XLEN-1:0] value,
  input  logic            signed_en,
  output logic [XLEN-1:0] magnitude,
  output logic            neg
);

  assign neg       = signed_en & value[XLEN-1];
  assign magnitude = neg ? twos_neg(value) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle over a shared
// hi/lo register pair, with a fast path for divide-by-zero and overflow.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | 32 shift-add / restoring-divide iterations
// DONE  | one-cycle done pulse, result valid
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t state, state_n;

  logic [2:0]      op_q;
  logic [4:0]      cnt;
  logic [XLEN-1:0] hi, lo, opnd;
  logic            neg_a_q, neg_b_q;

  logic            a_signed, b_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            a_neg, b_neg;

  logic            accept, is_div, div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_result;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_shift;
  logic            rem_ge;
  logic [XLEN-1:0] hi_step, lo_step;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, final_result;

  assign a_signed = (funct3 != FUNCT3_MULHU) && (funct3 != FUNCT3_DIVU) &&
                    (funct3 != FUNCT3_REMU);
  assign b_signed = a_signed && (funct3 != FUNCT3_MULHSU);

  magnitude_conv u_conv_a (
    .value     (rs1_val),
    .signed_en (a_signed),
    .magnitude (a_mag),
    .neg       (a_neg)
  );

  magnitude_conv u_conv_b (
    .value     (rs2_val),
    .signed_en (b_signed),
    .magnitude (b_mag),
    .neg       (b_neg)
  );

  assign accept   = (state == IDLE) && start && !flush;
  assign is_div   = funct3[2];
  assign div_zero = is_div && (rs2_val == '0);
  assign div_ovf  = is_div && !funct3[0] && (rs1_val == 32'h8000_0000) &&
                    (rs2_val == 32'hFFFF_FFFF);
  assign fast     = div_zero || div_ovf;

  always_comb begin
    fast_result = '0;
    if (div_zero)
      fast_result = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
    else if (div_ovf)
      fast_result = funct3[1] ? 32'h0 : 32'h8000_0000;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = fast ? DONE : RUN;
      RUN: begin
        if (flush)
          state_n = IDLE;
        else if (cnt == ITER_LAST)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One iteration: multiply adds opnd into hi when lo[0] is set and shifts the
  // pair right; divide shifts the pair left and subtracts opnd when it fits.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_shift = {hi, lo[XLEN-1]};
    rem_ge    = rem_shift >= {1'b0, opnd};
    if (op_q[2]) begin
      hi_step = rem_ge ? (rem_shift[XLEN-1:0] - opnd) : rem_shift[XLEN-1:0];
      lo_step = {lo[XLEN-2:0], rem_ge};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {hi_step, lo_step};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quot_fix = (neg_a_q ^ neg_b_q) ? twos_neg(lo_step) : lo_step;
    rem_fix  = neg_a_q ? twos_neg(hi_step) : hi_step;
    if (op_q[2])
      final_result = op_q[1] ? rem_fix : quot_fix;
    else
      final_result = (op_q == FUNCT3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= funct3;
      cnt     <= '0;
      hi      <= '0;
      neg_a_q <= a_neg;
      neg_b_q <= b_neg;
      lo      <= is_div ? a_mag : b_mag;
      opnd    <= is_div ? b_mag : a_mag;
      if (fast)
        result <= fast_result;
    end else if (state == RUN && !flush) begin
      cnt <= cnt + 5'd1;
      hi  <= hi_step;
      lo  <= lo_step;
      if (cnt == ITER_LAST)
        result <= final_result;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a 64-bit arithmetic
// reference model, including latency, flush, ignored start and mid-op reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_result = '0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .flush   (flush),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    p = '0;
    case (f3)
      FUNCT3_MUL:    p = sa * sb;
      FUNCT3_MULH:   p = (sa * sb) >> 32;
      FUNCT3_MULHSU: p = (sa * ub) >> 32;
      FUNCT3_MULHU:  p = (ua * ub) >> 32;
      FUNCT3_DIV:
        if (b == 0) p = 64'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h8000_0000;
        else p = sa / sb;
      FUNCT3_DIVU:   p = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
      FUNCT3_REM:
        if (b == 0) p = {32'b0, a};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h0;
        else p = sa % sb;
      default:       p = (b == 0) ? {32'b0, a} : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    int busy_cnt;
    bit fst;
    exp = ref_model(f3, a, b);
    fst = is_fast(f3, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom;
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    check($sformatf("latency f3=%0d a=%h b=%h", f3, a, b), 32'(lat), fst ? 32'd0 : 32'd32);
    check($sformatf("busy_cycles f3=%0d", f3), 32'(busy_cnt), fst ? 32'd0 : 32'd32);
    check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result, exp);
    @(posedge clk); #1;
    check("done_single_pulse", 32'(done), 32'd0);
    exp_result = exp;
  endtask

  logic [2:0]  dir_f3 [12] = '{FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHU, FUNCT3_MULHSU,
                               FUNCT3_DIV, FUNCT3_REM, FUNCT3_DIVU, FUNCT3_REMU,
                               FUNCT3_DIVU, FUNCT3_REM, FUNCT3_DIV, FUNCT3_REM};
  logic [31:0] dir_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b, prev, got;
    int dones;

    reset = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; rs1_val = '0; rs2_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      do_op(dir_f3[i], dir_a[i], dir_b[i]);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      do_op(f3, a, b);
    end

    // Flush sampled on the tenth edge after accept.
    prev = exp_result;
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_MUL; rs1_val = 32'd12345; rs2_val = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_flush", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result_kept", result, prev);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_result_still_kept", result, prev);

    // A start pulse during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_DIVU; rs1_val = 32'd100; rs2_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_MUL; rs1_val = 32'd3; rs2_val = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    got = '0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        got = result;
      end
    end
    check("start_in_run_done_count", 32'(dones), 32'd1);
    check("start_in_run_result", got, ref_model(FUNCT3_DIVU, 32'd100, 32'd7));

    // Reset sampled on the fifth edge after accept.
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_MULHU; rs1_val = $urandom; rs2_val = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    check("midrun_reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op(FUNCT3_REM, $urandom, $urandom | 32'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
